// File: rtl/rf_datapath_exec.sv
// RISC-core execute datapath: IR, 8x16 register file, A/B/C regs, shifter, ALU, Z/N/V; one control step per clk, no backpressure.
// Optional RF_WR_FWD_EN: read port bypasses the write mux so a same-edge loada/loadb sees the value being written.
module rf_datapath_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic        load_ir,
  input  logic [1:0]  vsel,
  input  logic [2:0]  nsel,
  input  logic        loada,
  input  logic        loadb,
  input  logic        asel,
  input  logic        bsel,
  input  logic        loadc,
  input  logic        loads,
  input  logic        write,
  input  logic [15:0] mdata,
  input  logic [7:0]  pc,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [15:0] datapath_out,
  output logic        Z_out,
  output logic        N_out,
  output logic        V_out
);

  logic [15:0] r_ir;
  logic [15:0] r_rf [0:7];
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_c;
  logic        r_z;
  logic        r_n;
  logic        r_v;

  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [2:0]  w_rm;
  logic [1:0]  w_shift;
  logic [1:0]  w_aluop;
  logic [15:0] w_sximm8;
  logic [15:0] w_sximm5;
  logic [2:0]  w_num;
  logic        w_nsel_ok;
  logic        w_wr_en;
  logic [15:0] w_wdata;
  logic [15:0] w_rdata;
  logic [15:0] w_bsh;
  logic [15:0] w_ain;
  logic [15:0] w_bin;
  logic [15:0] w_alu;
  logic        w_ovf;

  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_rm     = r_ir[2:0];
  assign w_shift  = r_ir[4:3];
  assign w_aluop  = r_ir[12:11];
  assign w_sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
  assign w_sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

  // One register number serves both ports; an illegal select reads R0 and never writes.
  always_comb begin
    w_num     = 3'd0;
    w_nsel_ok = 1'b1;
    case (nsel)
      3'b001:  w_num = w_rn;
      3'b010:  w_num = w_rd;
      3'b100:  w_num = w_rm;
      default: w_nsel_ok = 1'b0;
    endcase
  end

  assign w_wr_en = write & w_nsel_ok;

  always_comb begin
    w_wdata = r_c;
    case (vsel)
      2'b00:   w_wdata = r_c;
      2'b01:   w_wdata = {8'b0, pc};
      2'b10:   w_wdata = w_sximm8;
      default: w_wdata = mdata;
    endcase
  end

`ifdef RF_WR_FWD_EN
  assign w_rdata = w_wr_en ? w_wdata : r_rf[w_num];
`else
  assign w_rdata = r_rf[w_num];
`endif

  always_comb begin
    w_bsh = r_b;
    case (w_shift)
      2'b00:   w_bsh = r_b;
      2'b01:   w_bsh = {r_b[14:0], 1'b0};
      2'b10:   w_bsh = {1'b0, r_b[15:1]};
      default: w_bsh = {r_b[15], r_b[15:1]};
    endcase
  end

  assign w_ain = asel ? 16'h0000 : r_a;
  assign w_bin = bsel ? w_sximm5 : w_bsh;

  always_comb begin
    w_alu = 16'h0000;
    w_ovf = 1'b0;
    case (w_aluop)
      2'b00: begin
        w_alu = w_ain + w_bin;
        w_ovf = (w_ain[15] == w_bin[15]) && (w_alu[15] != w_ain[15]);
      end
      2'b01: begin
        w_alu = w_ain - w_bin;
        w_ovf = (w_ain[15] != w_bin[15]) && (w_alu[15] != w_ain[15]);
      end
      2'b10:   w_alu = w_ain & w_bin;
      default: w_alu = ~w_bin;
    endcase
  end

  // Reset wins over every enable, so a write in the reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir <= 16'h0000;
      r_a  <= 16'h0000;
      r_b  <= 16'h0000;
      r_c  <= 16'h0000;
      r_z  <= 1'b0;
      r_n  <= 1'b0;
      r_v  <= 1'b0;
      for (int i = 0; i < 8; i++) r_rf[i] <= 16'h0000;
    end else begin
      if (load_ir) r_ir <= instr_in;
      if (loada)   r_a  <= w_rdata;
      if (loadb)   r_b  <= w_rdata;
      if (loadc)   r_c  <= w_alu;
      if (loads) begin
        r_z <= (w_alu == 16'h0000);
        r_n <= w_alu[15];
        r_v <= w_ovf;
      end
      if (w_wr_en) r_rf[w_num] <= w_wdata;
    end
  end

  assign opcode       = r_ir[15:13];
  assign op           = r_ir[12:11];
  assign datapath_out = r_c;
  assign Z_out        = r_z;
  assign N_out        = r_n;
  assign V_out        = r_v;

endmodule

// File: doc/rf_datapath_exec.md
# rf_datapath_exec

Executing datapath for the simple RISC core: receives the per-cycle control word (vsel, nsel, loada, loadb, asel, bsel, loadc, loads, write) from the controller FSM and carries it out. It holds the instruction register, an 8×16 register file, the A/B/C pipeline registers, the shifter, the ALU and the status flags. It is the responder end of the controller's control interface: every controller state maps to exactly one clock edge of work here.

## Interface
- No parameters; width fixed at 16 bits, 8 registers.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all state.
- instr_in  input  16  instruction word; captured into IR when load_ir=1.
- load_ir  input  1  IR load enable.
- vsel  input  2  writeback source: 00 C, 01 {8'b0,pc}, 10 sximm8, 11 mdata.
- nsel  input  3  one-hot register field select: 001 Rn, 010 Rd, 100 Rm.
- loada / loadb / loadc / loads  input  1 each  load A, B, C, status.
- asel  input  1  1: ALU A operand = 0; 0: A register.
- bsel  input  1  1: ALU B operand = sximm5; 0: shifted B.
- write  input  1  register-file write enable.
- mdata  input  16  memory data for vsel=11.
- pc  input  8  program counter for vsel=01.
- opcode  output  3  IR[15:13], to controller.
- op  output  2  IR[12:11], to controller.
- datapath_out  output  16  C register.
- Z_out, N_out, V_out  output  1 each  status flags.

## Operation
- Decode (combinational from IR): Rn=IR[10:8], Rd=IR[7:5], Rm=IR[2:0], shift=IR[4:3], ALUop=IR[12:11], sximm8=sign-extend IR[7:0], sximm5=sign-extend IR[4:0].
- Register number = field selected by nsel; shared by read and write port. Non-one-hot nsel: number forced to 0 and write suppressed.
- Read data = R[number] (old value unless forwarding enabled, see Configuration).
- loada: A ← read data. loadb: B ← read data.
- Shifter on B: 00 pass, 01 LSL1 (LSB=0), 10 LSR1 (MSB=0), 11 ASR1 (MSB copied).
- ALU: 00 A+B, 01 A−B, 10 A&B, 11 ~B; result truncated to 16 bits.
- loadc: C ← ALU result. loads: Z ← (result==0), N ← result[15], V ← signed overflow for 00/01, V ← 0 for 10/11.
- write: R[number] ← vsel mux.
- All enables independent; any subset may be asserted in one cycle.
- MOV Rd,Rm{,sh}: asel=1, ALUop taken from IR (00), result = 0 + shifted B.

## Timing
- All state updates on rising clk; no combinational path from control inputs to outputs except through registers; opcode/op follow IR one cycle after load_ir.
- Latency per controller step: 1 cycle. ALU op: loada edge, loadb edge, loadc/loads edge → datapath_out valid after 3rd edge; write edge 4th.
- Reset: R0–R7, IR, A, B, C = 16'h0000; Z=N=V=0; opcode=000, op=00, datapath_out=0. Reset dominates every enable in the same cycle (reset with write=1: register stays 0).
- Reset mid-instruction: all partial results discarded; next non-reset edge starts from cleared state.
- load_ir concurrent with loada/loadb: field decode uses the old IR for that edge.
- write and loada/loadb to same register in same edge: A/B receive old value (without forwarding).

## Configuration
- RF_WR_FWD_EN defined: read port bypasses the write mux when write=1 and nsel is valid, so a simultaneous loada/loadb gets the value being written.
- Not defined: read port always returns the stored (pre-edge) value.

## Test plan
- Reset, then load_ir 16'hD0FD (MOV R0,#-3), nsel=001 vsel=10 write=1 → R0=16'hFFFD; opcode=110 op=10.
- R1=7, R2=5, IR=ADD R3,R1,R2,LSL#1 (16'hA16A); loada(Rn), loadb(Rm), loadc+loads, write(Rd,vsel=00) → R3=16'h0011, Z=N=V=0.
- R1=16'h8000, R2=1, ALUop=01 → datapath_out=16'h7FFF, V=1, N=0, Z=0; AND R1,R1 → 16'h8000, N=1, V=0.
- MOV with asel=1, Rm=16'hFFFC, shift=11 → C=16'hFFFE, N=1; shift=10 → C=16'h7FFE.
- R4=1, same edge write R4←16'h0055 (vsel=10) and loada R4 → A=1 without RF_WR_FWD_EN, A=16'h0055 with it.
- Assert reset with write=1, loadc=1 mid-sequence → all registers, C and flags read 0 next cycle; nsel=011 with write=1 → no register changes.
